// File: rtl/router_pkg.sv
// Shared types and constants for the router link: flit type tags, default
// field widths and the transmitter FSM state encoding.
package router_pkg;

    localparam int ROUTER_ADDR_W = 30;
    localparam int ROUTER_FLIT_W = 32;
    localparam int ROUTER_LEN_W  = 5;

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_SRC  = 2'b10;

    typedef enum logic [1:0] {IDLE, HEAD, SRC, BODY} tx_state_t;

endpackage

// File: rtl/router_flit_fmt.sv
// Pure combinational packing of head/source flits: type tag in the top two
// bits, zero pad, address in the low bits. Shared with the RX-side checker.
module router_flit_fmt
    import router_pkg::*;
#(
    parameter int ADDR_W = ROUTER_ADDR_W,
    parameter int FLIT_W = ROUTER_FLIT_W
) (
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W-1:0] i_src,
    output logic [FLIT_W-1:0] o_head,
    output logic [FLIT_W-1:0] o_src
);

    // Field-by-field assignment avoids a zero-width replication when FLIT_W == ADDR_W+2.
    always_comb begin
        o_head                  = '0;
        o_head[ADDR_W-1:0]      = i_dst;
        o_head[FLIT_W-1 -: 2]   = FT_HEAD;
        o_src                   = '0;
        o_src[ADDR_W-1:0]       = i_src;
        o_src[FLIT_W-1 -: 2]    = FT_SRC;
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: serialises a descriptor into HEAD, SRC and LEN payload
// flits on a valid/ready link; payload words pass straight through in BODY.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int ADDR_W = ROUTER_ADDR_W,
    parameter int FLIT_W = ROUTER_FLIT_W,
    parameter int LEN_W  = ROUTER_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [ADDR_W-1:0] req_src,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [FLIT_W-1:0] pl_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [FLIT_W-1:0] tx_data,
    output logic              tx_last,
    output logic              busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_src;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rem;
    logic [FLIT_W-1:0] w_head_flit;
    logic [FLIT_W-1:0] w_src_flit;
    logic              w_req_hs;
    logic              w_pl_hs;

    router_flit_fmt #(
        .ADDR_W (ADDR_W),
        .FLIT_W (FLIT_W)
    ) u_fmt (
        .i_dst  (r_dst),
        .i_src  (r_src),
        .o_head (w_head_flit),
        .o_src  (w_src_flit)
    );

    assign w_req_hs = req_valid && req_ready;
    assign w_pl_hs  = (r_state == BODY) && pl_valid && tx_ready;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dst   <= '0;
            r_src   <= '0;
            r_len   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_hs) begin
                r_dst <= req_dst;
                r_src <= req_src;
                r_len <= req_len;
                r_rem <= req_len;
            end else if (w_pl_hs) begin
                r_rem <= r_rem - LEN_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        tx_last     = 1'b0;
        pl_ready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = HEAD;
            end
            HEAD: begin
                tx_valid = 1'b1;
                tx_data  = w_head_flit;
                if (tx_ready) w_state_nxt = SRC;
            end
            SRC: begin
                tx_valid = 1'b1;
                tx_data  = w_src_flit;
                tx_last  = (r_len == '0);
                if (tx_ready) w_state_nxt = (r_len == '0) ? IDLE : BODY;
            end
            BODY: begin
                // No buffering: link stability in BODY is inherited from the payload source.
                tx_valid = pl_valid;
                tx_data  = pl_data;
                pl_ready = tx_ready;
                tx_last  = (r_rem == LEN_ONE);
                if (w_pl_hs && (r_rem == LEN_ONE)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: directed descriptors push expected flits,
// a negedge monitor pops and compares every transferred flit.
module tb_router_pkt_tx;

    localparam int ADDR_W = 30;
    localparam int FLIT_W = 32;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_dst = '0;
    logic [ADDR_W-1:0] req_src = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic              pl_valid = 1'b0;
    logic              pl_ready;
    logic [FLIT_W-1:0] pl_data = '0;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic [FLIT_W-1:0] tx_data;
    logic              tx_last;
    logic              busy;

    always #5 clk = ~clk;

    router_pkt_tx #(.ADDR_W(ADDR_W), .FLIT_W(FLIT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_src(req_src), .req_len(req_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [FLIT_W:0]   exp_q[$];
    logic [FLIT_W-1:0] pay_q[$];
    bit tx_rand = 0;
    bit pl_take = 0;
    bit in_bubble = 0;
    int pl_taken = 0;
    int gap_trig = -1;
    int gap_left = 0;
    int pl_hs_cnt = 0;
    int plr_cnt = 0;
    bit held_v = 0;
    logic [FLIT_W-1:0] held_d = '0;
    logic held_l = 1'b0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    // Monitor: values seen at negedge are the ones the next rising edge acts on.
    initial forever begin
        logic [FLIT_W:0] e;
        @(negedge clk);
        if (!rst_n) begin
            held_v  = 0;
            pl_take = 0;
        end else begin
            if (held_v)
                chk("stall_hold", tx_valid && tx_data == held_d && tx_last == held_l,
                    {tx_valid, tx_last, tx_data}, {1'b1, held_l, held_d});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("unexpected_flit", 0, {tx_last, tx_data}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("flit", {tx_last, tx_data} == e, {tx_last, tx_data}, e);
                end
            end
            held_v = tx_valid && !tx_ready;
            held_d = tx_data;
            held_l = tx_last;
            chk("req_ready_vs_busy", req_ready == !busy, {busy, req_ready}, {busy, !busy});
            if (in_bubble) chk("bubble_tx_valid", !tx_valid, tx_valid, 0);
            if (pl_ready) plr_cnt++;
            pl_take = pl_valid && pl_ready;
            if (pl_take) pl_hs_cnt++;
        end
    end

    // Payload source and tx_ready driver; pl_valid only drops right after a take.
    initial forever begin
        @(posedge clk);
        #1;
        if (pl_take && pay_q.size() > 0) begin
            void'(pay_q.pop_front());
            pl_taken++;
        end
        if (pl_taken == gap_trig) begin
            gap_left = 3;
            gap_trig = -1;
        end
        if (gap_left > 0) begin
            in_bubble = 1;
            pl_valid  = 1'b0;
            gap_left--;
        end else begin
            in_bubble = 0;
            pl_valid  = (pay_q.size() > 0);
        end
        pl_data  = (pay_q.size() > 0) ? pay_q[0] : '0;
        tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] s, input int len,
                        input logic [FLIT_W-1:0] base, input logic [FLIT_W-1:0] e_head,
                        input logic [FLIT_W-1:0] e_src);
        bit ok = 0;
        exp_q.push_back({1'b0, e_head});
        exp_q.push_back({len == 0, e_src});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({i == len - 1, base + FLIT_W'(i)});
            pay_q.push_back(base + FLIT_W'(i));
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_dst = d; req_src = s; req_len = LEN_W'(len);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("req_accept_timeout", 0, 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("head_latency", tx_valid && tx_data == e_head, {tx_valid, tx_data}, {1'b1, e_head});
    endtask

    task automatic wait_idle(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk); #1;
            if (!busy && exp_q.size() == 0) begin cyc = c; break; end
        end
        if (cyc < 0) chk("drain_timeout", 0, exp_q.size(), 0);
    endtask

    initial begin
        int cyc, base_hs, base_plr;
        bit ok;
        #12;
        chk("rst_outputs", !tx_valid && tx_data == '0 && !tx_last && !pl_ready && !busy && req_ready,
            {tx_valid, tx_last, pl_ready, busy, req_ready, tx_data}, {5'b00001, 32'h0});
        #10 rst_n = 1'b1;

        // 1: basic packet, two payload words
        base_hs = pl_hs_cnt;
        send(30'h1234567, 30'h0ABCDEF, 2, 32'hA0, 32'h41234567, 32'h80ABCDEF);
        wait_idle(50, cyc);
        chk("t1_cycles", cyc == 4, cyc, 4);
        chk("t1_req_ready_back", req_ready, req_ready, 1);
        chk("t1_pl_hs", pl_hs_cnt - base_hs == 2, pl_hs_cnt - base_hs, 2);

        // 2: zero-length packet
        base_plr = plr_cnt;
        send(30'h3FFFFFFF, 30'h0000001, 0, 32'h0, 32'h7FFFFFFF, 32'h80000001);
        wait_idle(50, cyc);
        chk("t2_cycles", cyc == 2, cyc, 2);
        chk("t2_pl_ready_never", plr_cnt == base_plr, plr_cnt - base_plr, 0);

        // 3: max length under random backpressure
        tx_rand = 1;
        base_hs = pl_hs_cnt;
        send(30'h2AAAAAAA, 30'h1555555, 31, 32'h100, 32'h6AAAAAAA, 32'h81555555);
        wait_idle(600, cyc);
        tx_rand = 0;
        chk("t3_pl_hs", pl_hs_cnt - base_hs == 31, pl_hs_cnt - base_hs, 31);

        // 4: 3-cycle payload bubble after two words
        gap_trig = pl_taken + 2;
        send(30'h0000010, 30'h0000020, 5, 32'h200, 32'h40000010, 32'h80000020);
        wait_idle(60, cyc);
        chk("t4_bubble_taken", gap_trig == -1, gap_trig, 32'hFFFFFFFF);

        // 5: async reset mid-BODY with rem == 5
        base_hs = pl_hs_cnt;
        send(30'h0000030, 30'h0000040, 10, 32'h300, 32'h40000030, 32'h80000040);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (pl_hs_cnt - base_hs == 5) begin ok = 1; break; end
        end
        chk("t5_reach_rem5", ok, pl_hs_cnt - base_hs, 5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", !tx_valid && tx_data == '0 && !tx_last && !pl_ready && !busy && req_ready,
            {tx_valid, tx_last, pl_ready, busy, req_ready, tx_data}, {5'b00001, 32'h0});
        exp_q.delete();
        pay_q.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        send(30'h0000050, 30'h0000060, 1, 32'h400, 32'h40000050, 32'h80000060);
        wait_idle(50, cyc);
        chk("t5_clean_cycles", cyc == 3, cyc, 3);

        // 6: second descriptor held while first packet is in flight
        send(30'h0000070, 30'h0000080, 3, 32'h500, 32'h40000070, 32'h80000080);
        send(30'h0000090, 30'h00000A0, 1, 32'h600, 32'h40000090, 32'h800000A0);
        wait_idle(50, cyc);

        chk("end_exp_empty", exp_q.size() == 0, exp_q.size(), 0);
        chk("end_pay_empty", pay_q.size() == 0, pay_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
